// File: rtl/eco32_timer_cfg_loader.sv
// eco32_timer_cfg_loader
// Sequences the reprogramming of eco32_timer_box over its ul_eve command port.
// A local slot table is filled by the host. On ld_start the block issues
// disable, clock divider, N slot configs, slot count and (when N>0) enable.
// An abort finishes the command in flight and then leaves the timer disabled.
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   tbl_wr_stb/slot/data             host write port of the slot table
//   ld_start, ld_slot_cnt, ld_clk_div  load request and its parameters
//   ld_abort                         abort request while busy
//   ld_busy, ld_done, ld_aborted     status; done/aborted are 1-cycle pulses
//   ul_eve_stb/cmd/ptr, ul_eve_ack   command port towards the timer
module eco32_timer_cfg_loader #(
    parameter int unsigned TBL_AW       = 8,
    parameter logic [7:0]  CMD_SET_ENA  = 8'h30,
    parameter logic [7:0]  CMD_SLOT_CFG = 8'h31,
    parameter logic [7:0]  CMD_SLOT_CNT = 8'h32,
    parameter logic [7:0]  CMD_CLK_DIV  = 8'h33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tbl_wr_stb,
    input  logic [7:0]  tbl_wr_slot,
    input  logic [27:0] tbl_wr_data,
    input  logic        ld_start,
    input  logic [8:0]  ld_slot_cnt,
    input  logic [31:0] ld_clk_div,
    input  logic        ld_abort,
    output logic        ld_busy,
    output logic        ld_done,
    output logic        ld_aborted,
    output logic        ul_eve_stb,
    output logic [7:0]  ul_eve_cmd,
    output logic [35:0] ul_eve_ptr,
    input  logic        ul_eve_ack
);

    localparam int unsigned DEPTH   = 1 << TBL_AW;
    localparam int unsigned CNT_W   = 9;
    localparam int unsigned DIV_W   = 32;
    localparam int unsigned ENTRY_W = 28;
    localparam int unsigned CMD_W   = 8;
    localparam int unsigned PTR_W   = 36;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIS   = 3'd1,
        ST_DIV   = 3'd2,
        ST_FETCH = 3'd3,
        ST_SLOT  = 3'd4,
        ST_CNT   = 3'd5,
        ST_ENA   = 3'd6,
        ST_ABT   = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               abort_q, abort_d;
    logic               stb_q, stb_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    logic [ENTRY_W-1:0] tbl_mem [DEPTH];
    logic [ENTRY_W-1:0] tbl_rd_q;
    logic [TBL_AW-1:0]  tbl_rd_addr;

    logic               cmd_done;
    logic               abort_now;
    logic [CNT_W-1:0]   idx_inc;

    assign cmd_done  = stb_q & ul_eve_ack;
    assign abort_now = abort_q | ld_abort;
    assign idx_inc   = idx_q + CNT_W'(1);
    // Read one step ahead so the entry is ready while in FETCH.
    assign tbl_rd_addr = idx_d[TBL_AW-1:0];

    // Slot table: synchronous write, registered read returning old data on collision.
    always_ff @(posedge clk) begin
        if (tbl_wr_stb) begin
            tbl_mem[tbl_wr_slot[TBL_AW-1:0]] <= tbl_wr_data;
        end
        tbl_rd_q <= tbl_mem[tbl_rd_addr];
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            div_q     <= '0;
            abort_q   <= 1'b0;
            stb_q     <= 1'b0;
            cmd_q     <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            abort_q   <= abort_d;
            stb_q     <= stb_d;
            cmd_q     <= cmd_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Next state: every command state advances only on a completed handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        abort_d = abort_q;
        if (state_q != ST_IDLE && ld_abort) begin
            abort_d = 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (ld_start) begin
                    state_d = ST_DIS;
                    cnt_d   = (ld_slot_cnt > DEPTH_CNT) ? DEPTH_CNT : ld_slot_cnt;
                    div_d   = ld_clk_div;
                end
            end
            ST_DIS: begin
                idx_d = '0;
                if (cmd_done) begin
                    state_d = abort_now ? ST_IDLE : ST_DIV;
                end
            end
            ST_DIV: begin
                if (cmd_done) begin
                    if (abort_now)          state_d = ST_ABT;
                    else if (cnt_q != '0)   state_d = ST_FETCH;
                    else                    state_d = ST_CNT;
                end
            end
            ST_FETCH: begin
                state_d = abort_now ? ST_ABT : ST_SLOT;
            end
            ST_SLOT: begin
                if (cmd_done) begin
                    idx_d = idx_inc;
                    if (abort_now)            state_d = ST_ABT;
                    else if (idx_inc < cnt_q) state_d = ST_FETCH;
                    else                      state_d = ST_CNT;
                end
            end
            ST_CNT: begin
                if (cmd_done) begin
                    if (abort_now)          state_d = ST_ABT;
                    else if (cnt_q != '0)   state_d = ST_ENA;
                    else                    state_d = ST_IDLE;
                end
            end
            ST_ENA: begin
                if (cmd_done) begin
                    state_d = abort_now ? ST_ABT : ST_IDLE;
                end
            end
            ST_ABT: begin
                if (cmd_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle; a pending command is frozen until acked.
    always_comb begin
        stb_d     = 1'b0;
        cmd_d     = '0;
        ptr_d     = '0;
        busy_d    = (state_d != ST_IDLE);
        done_d    = 1'b0;
        aborted_d = 1'b0;
        if (state_q != ST_IDLE && state_d == ST_IDLE) begin
            done_d    = ~abort_now;
            aborted_d = abort_now;
        end
        if (stb_q && !ul_eve_ack) begin
            stb_d = 1'b1;
            cmd_d = cmd_q;
            ptr_d = ptr_q;
        end else begin
            unique case (state_d)
                ST_DIS, ST_ABT: begin
                    stb_d = 1'b1;
                    cmd_d = CMD_SET_ENA;
                    ptr_d = '0;
                end
                ST_DIV: begin
                    stb_d = 1'b1;
                    cmd_d = CMD_CLK_DIV;
                    ptr_d = {4'd0, div_q};
                end
                ST_SLOT: begin
                    stb_d = 1'b1;
                    cmd_d = CMD_SLOT_CFG;
                    ptr_d = {tbl_rd_q[27], tbl_rd_q[26:8], idx_q[7:0], tbl_rd_q[7:0]};
                end
                ST_CNT: begin
                    stb_d = 1'b1;
                    cmd_d = CMD_SLOT_CNT;
                    ptr_d = {27'd0, cnt_q};
                end
                ST_ENA: begin
                    stb_d = 1'b1;
                    cmd_d = CMD_SET_ENA;
                    ptr_d = PTR_W'(1);
                end
                default: begin
                    stb_d = 1'b0;
                end
            endcase
        end
    end

    assign ld_busy    = busy_q;
    assign ld_done    = done_q;
    assign ld_aborted = aborted_q;
    assign ul_eve_stb = stb_q;
    assign ul_eve_cmd = cmd_q;
    assign ul_eve_ptr = ptr_q;

endmodule

// File: tb/tb_eco32_timer_cfg_loader.sv
// Testbench for eco32_timer_cfg_loader: vector table of loads with known
// latency, hand sequences for abort / reset / start-while-busy, and random
// loads checked against a command-list model of the reprogramming sequence.
module tb_eco32_timer_cfg_loader;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [35:0] ptr;
    } cmd_t;

    typedef struct {
        int          cnt;
        logic [31:0] div;
        int unsigned ack_dly;
        int          exp_ncmd;
        int          exp_done_t;
        int          exp_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tbl_wr_stb;
    logic [7:0]  tbl_wr_slot;
    logic [27:0] tbl_wr_data;
    logic        ld_start;
    logic [8:0]  ld_slot_cnt;
    logic [31:0] ld_clk_div;
    logic        ld_abort;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_aborted;
    logic        ul_eve_stb;
    logic [7:0]  ul_eve_cmd;
    logic [35:0] ul_eve_ptr;
    logic        ul_eve_ack;

    int n_vec = 0;
    int n_err = 0;

    // Table mirror, expected and observed command streams.
    logic [27:0] tbl_m [256];
    cmd_t        exp_q[$];
    cmd_t        log_q[$];
    int          n_done_mon = 0;
    int          n_ab_mon   = 0;
    int          stab_viol  = 0;

    // Ack responder: fixed or per-command random delay, 0 = same-cycle ack.
    int unsigned ack_base = 0;
    logic        ack_rand = 1'b0;
    int unsigned wait_cnt = 0;
    int unsigned cur_delay = 0;

    eco32_timer_cfg_loader dut (
        .clk         (clk),
        .rst         (rst),
        .tbl_wr_stb  (tbl_wr_stb),
        .tbl_wr_slot (tbl_wr_slot),
        .tbl_wr_data (tbl_wr_data),
        .ld_start    (ld_start),
        .ld_slot_cnt (ld_slot_cnt),
        .ld_clk_div  (ld_clk_div),
        .ld_abort    (ld_abort),
        .ld_busy     (ld_busy),
        .ld_done     (ld_done),
        .ld_aborted  (ld_aborted),
        .ul_eve_stb  (ul_eve_stb),
        .ul_eve_cmd  (ul_eve_cmd),
        .ul_eve_ptr  (ul_eve_ptr),
        .ul_eve_ack  (ul_eve_ack)
    );

    always #5 clk = ~clk;

    assign ul_eve_ack = ul_eve_stb && (wait_cnt >= (ack_rand ? cur_delay : ack_base));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
        end else if (ul_eve_stb && ul_eve_ack) begin
            wait_cnt  <= 0;
            cur_delay <= $urandom_range(0, 3);
        end else if (ul_eve_stb) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Monitor: logs accepted commands, counts pulses, checks hold-until-ack.
    logic        pend = 1'b0;
    logic [7:0]  pcmd = '0;
    logic [35:0] pptr = '0;
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend && !(ul_eve_stb && ul_eve_cmd == pcmd && ul_eve_ptr == pptr))
                stab_viol++;
            if (ul_eve_stb && ul_eve_ack) log_q.push_back(cmd_t'({ul_eve_cmd, ul_eve_ptr}));
            if (ld_done) n_done_mon++;
            if (ld_aborted) n_ab_mon++;
            pend = ul_eve_stb && !ul_eve_ack;
            pcmd = ul_eve_cmd;
            pptr = ul_eve_ptr;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected command list for a load of cnt slots (count clamped to the table size).
    task automatic build_expected(input int cnt, input logic [31:0] div);
        int n;
        logic [27:0] e;
        n = (cnt > 256) ? 256 : cnt;
        exp_q.delete();
        exp_q.push_back(cmd_t'({8'h30, 36'd0}));
        exp_q.push_back(cmd_t'({8'h33, 4'd0, div}));
        for (int i = 0; i < n; i++) begin
            e = tbl_m[i];
            exp_q.push_back(cmd_t'({8'h31, e[27], e[26:8], 8'(i), e[7:0]}));
        end
        exp_q.push_back(cmd_t'({8'h32, 36'(n)}));
        if (n > 0) exp_q.push_back(cmd_t'({8'h30, 36'd1}));
    endtask

    task automatic compare_log(input string tag, input int start);
        int got_n;
        got_n = log_q.size() - start;
        check({tag, " ncmd"}, 64'(got_n), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_n; i++)
            check($sformatf("%s cmd[%0d]", tag, i), 64'(log_q[start + i]), 64'(exp_q[i]));
    endtask

    task automatic wr_tbl(input int slot, input logic [27:0] data);
        @(negedge clk);
        tbl_wr_stb  = 1'b1;
        tbl_wr_slot = 8'(slot);
        tbl_wr_data = data;
        @(posedge clk);
        #1 tbl_wr_stb = 1'b0;
        tbl_m[slot] = data;
    endtask

    // Pulse ld_start (optionally with ld_abort) and wait for done/aborted.
    // done_t counts cycles after the start edge (start cycle is T0).
    task automatic run_load(input int cnt, input logic [31:0] div, input logic with_abort,
                            output int done_t, output int busy_n, output logic was_abort);
        @(negedge clk);
        ld_start    = 1'b1;
        ld_abort    = with_abort;
        ld_slot_cnt = 9'(cnt);
        ld_clk_div  = div;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        ld_abort = 1'b0;
        done_t = -1;
        busy_n = 0;
        was_abort = 1'b0;
        for (int t = 1; t <= 2000; t++) begin
            @(negedge clk);
            if (ld_busy) busy_n++;
            if (ld_done || ld_aborted) begin
                done_t = t;
                was_abort = ld_aborted;
                break;
            end
        end
    endtask

    initial begin
        vec_t  vt[7];
        int    done_t, busy_n, start, d0, a0, s0, cnt;
        logic  was_ab, found, seen_done, seen_ab;
        logic [31:0] div;

        vt[0] = '{2,   32'd100,       0, 6,   9,   8};
        vt[1] = '{2,   32'd100,       3, 6,   27,  26};
        vt[2] = '{0,   32'd7,         0, 3,   4,   3};
        vt[3] = '{300, 32'hDEAD_BEEF, 0, 260, 517, 516};
        vt[4] = '{1,   32'd5,         1, 5,   12,  11};
        vt[5] = '{256, 32'd1,         0, 260, 517, 516};
        vt[6] = '{0,   32'd0,         2, 3,   10,  9};

        rst = 1'b1;
        tbl_wr_stb = 1'b0; tbl_wr_slot = '0; tbl_wr_data = '0;
        ld_start = 1'b0; ld_slot_cnt = '0; ld_clk_div = '0; ld_abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ld_busy",    64'(ld_busy),    64'd0);
        check("rst ld_done",    64'(ld_done),    64'd0);
        check("rst ld_aborted", 64'(ld_aborted), 64'd0);
        check("rst ul_eve_stb", 64'(ul_eve_stb), 64'd0);
        check("rst ul_eve_cmd", 64'(ul_eve_cmd), 64'd0);
        check("rst ul_eve_ptr", 64'(ul_eve_ptr), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            if (i == 0)      wr_tbl(i, {1'b1, 19'd5, 8'hA1});
            else if (i == 1) wr_tbl(i, {1'b0, 19'd9, 8'hB2});
            else             wr_tbl(i, 28'($urandom));
        end

        // Table-driven loads with fixed ack delay and known latency.
        for (int v = 0; v < 7; v++) begin
            ack_base = vt[v].ack_dly;
            ack_rand = 1'b0;
            build_expected(vt[v].cnt, vt[v].div);
            start = log_q.size(); d0 = n_done_mon; a0 = n_ab_mon; s0 = stab_viol;
            run_load(vt[v].cnt, vt[v].div, 1'b0, done_t, busy_n, was_ab);
            check($sformatf("v%0d busy at done", v), 64'(ld_busy), 64'd0);
            repeat (2) @(negedge clk);
            compare_log($sformatf("v%0d", v), start);
            check($sformatf("v%0d ncmd const", v), 64'(log_q.size() - start), 64'(vt[v].exp_ncmd));
            check($sformatf("v%0d done cycle", v), 64'(done_t), 64'(vt[v].exp_done_t));
            check($sformatf("v%0d busy cycles", v), 64'(busy_n), 64'(vt[v].exp_busy));
            check($sformatf("v%0d aborted", v), 64'(was_ab), 64'd0);
            check($sformatf("v%0d done pulses", v), 64'(n_done_mon - d0), 64'd1);
            check($sformatf("v%0d abort pulses", v), 64'(n_ab_mon - a0), 64'd0);
            check($sformatf("v%0d hold stable", v), 64'(stab_viol - s0), 64'd0);
            if (v == 0)
                check("v0 slot0 literal", 64'(log_q[start + 2]),
                      64'({8'h31, 1'b1, 19'd5, 8'h00, 8'hA1}));
        end

        // Start and abort together in IDLE: start wins.
        ack_base = 0;
        build_expected(0, 32'd3);
        start = log_q.size(); d0 = n_done_mon; a0 = n_ab_mon;
        run_load(0, 32'd3, 1'b1, done_t, busy_n, was_ab);
        repeat (2) @(negedge clk);
        compare_log("start+abort", start);
        check("start+abort done cycle", 64'(done_t), 64'd4);
        check("start+abort aborted", 64'(was_ab), 64'd0);
        check("start+abort done pulses", 64'(n_done_mon - d0), 64'd1);

        // Abort during the second slot command, plus a stray start while busy.
        ack_base = 2;
        build_expected(4, 32'h55);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        exp_q.push_back(cmd_t'({8'h30, 36'd0}));
        start = log_q.size(); d0 = n_done_mon; a0 = n_ab_mon; s0 = stab_viol;
        @(negedge clk);
        ld_start = 1'b1; ld_slot_cnt = 9'd4; ld_clk_div = 32'h55;
        @(posedge clk);
        #1 ld_start = 1'b0;
        @(negedge clk);
        ld_start = 1'b1; ld_slot_cnt = 9'd9; ld_clk_div = 32'h99;
        @(posedge clk);
        #1 ld_start = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ul_eve_stb && ul_eve_cmd == 8'h31 && ul_eve_ptr[15:8] == 8'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("abort slot1 seen", 64'(found), 64'd1);
        ld_abort = 1'b1;
        @(posedge clk);
        #1 ld_abort = 1'b0;
        seen_done = 1'b0; seen_ab = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ld_done || ld_aborted) begin
                seen_done = ld_done;
                seen_ab = ld_aborted;
                break;
            end
        end
        check("abort ld_aborted", 64'(seen_ab), 64'd1);
        check("abort ld_done", 64'(seen_done), 64'd0);
        repeat (3) @(negedge clk);
        compare_log("abort", start);
        check("abort done pulses", 64'(n_done_mon - d0), 64'd0);
        check("abort abort pulses", 64'(n_ab_mon - a0), 64'd1);
        check("abort hold stable", 64'(stab_viol - s0), 64'd0);
        check("abort idle after", 64'(ld_busy), 64'd0);

        // Reset while the divider command waits for ack.
        ack_base = 5;
        @(negedge clk);
        ld_start = 1'b1; ld_slot_cnt = 9'd1; ld_clk_div = 32'h1234;
        @(posedge clk);
        #1 ld_start = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ul_eve_stb && ul_eve_cmd == 8'h33) begin
                found = 1'b1;
                break;
            end
        end
        check("rst div seen", 64'(found), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst mid stb", 64'(ul_eve_stb), 64'd0);
        check("rst mid busy", 64'(ld_busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ack_base = 0;
        build_expected(1, 32'hCAFE);
        start = log_q.size(); d0 = n_done_mon;
        run_load(1, 32'hCAFE, 1'b0, done_t, busy_n, was_ab);
        repeat (2) @(negedge clk);
        compare_log("post-rst", start);
        check("post-rst done cycle", 64'(done_t), 64'd7);
        check("post-rst done pulses", 64'(n_done_mon - d0), 64'd1);

        // Random loads with random ack delays against the model.
        ack_rand = 1'b1;
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < int'($urandom_range(0, 4)); k++)
                wr_tbl(int'($urandom_range(0, 255)), 28'($urandom));
            cnt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(250, 511))
                                              : int'($urandom_range(0, 24));
            div = $urandom;
            build_expected(cnt, div);
            start = log_q.size(); d0 = n_done_mon; a0 = n_ab_mon; s0 = stab_viol;
            run_load(cnt, div, 1'b0, done_t, busy_n, was_ab);
            check($sformatf("r%0d finished", it), 64'(done_t > 0), 64'd1);
            repeat (2) @(negedge clk);
            compare_log($sformatf("r%0d", it), start);
            check($sformatf("r%0d done pulses", it), 64'(n_done_mon - d0), 64'd1);
            check($sformatf("r%0d abort pulses", it), 64'(n_ab_mon - a0), 64'd0);
            check($sformatf("r%0d hold stable", it), 64'(stab_viol - s0), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eco32_timer_cfg_loader.md
Name: eco32_timer_cfg_loader

Overview:
- Upstream command sequencer for eco32_timer_box; drives the timer's ul_eve command port.
- Holds a local 256-entry slot table written by a host port.
- On ld_start, issues the full reprogramming sequence: disable, clk_div, N slot configs, valid slot count, then enable.
- Frees the host from ordering timer commands by hand and guarantees the timer is disabled while it is being reconfigured.

Parameters:
- TBL_AW, 8, slot table address width; depth is 2^TBL_AW and must be <= 256.
- CMD_SET_ENA, 8'h30, timer enable command code.
- CMD_SLOT_CFG, 8'h31, slot config command code.
- CMD_SLOT_CNT, 8'h32, valid slot count command code.
- CMD_CLK_DIV, 8'h33, clock divider command code.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- tbl_wr_stb  in  1  slot table write strobe
- tbl_wr_slot  in  8  table address; only the low TBL_AW bits are used
- tbl_wr_data  in  28  slot entry {ena[27], cv[26:8], id[7:0]}
- ld_start  in  1  start-load pulse
- ld_slot_cnt  in  9  number of slots to load, 0..256
- ld_clk_div  in  32  divider value to program
- ld_abort  in  1  abort request
- ld_busy  out  1  sequence in progress
- ld_done  out  1  one-cycle pulse on normal completion
- ld_aborted  out  1  one-cycle pulse on completion after an abort
- ul_eve_stb  out  1  command valid
- ul_eve_cmd  out  8  command code
- ul_eve_ptr  out  36  command payload
- ul_eve_ack  in  1  command accepted; may be combinational from ul_eve_stb

Behaviour:
- Reset: state IDLE. ld_busy=0, ld_done=0, ld_aborted=0, ul_eve_stb=0, ul_eve_cmd=0, ul_eve_ptr=0. All outputs are registered.
- Table: 2^TBL_AW x 28 RAM.
  - Write is synchronous on tbl_wr_stb and is allowed at any time, including while busy.
  - Read is synchronous with 1-cycle latency.
  - Simultaneous read and write of the same address returns the old data.
  - The table is not cleared by rst.
- Handshake:
  - Once ul_eve_stb is asserted, stb, cmd and ptr are held stable until ul_eve_ack=1 is sampled.
  - The next command may appear in the cycle after the ack, so stb may stay high back-to-back.
  - An ack while stb=0 is ignored.
- ld_start is honoured only in IDLE. In IDLE, ld_slot_cnt and ld_clk_div are latched.
  - A latched count above 2^TBL_AW is clamped to 2^TBL_AW.
  - ld_start while busy is ignored.
- States (each command state waits for ack before advancing):
  - IDLE: on ld_start -> DIS, with busy=1 from the next cycle.
  - DIS: cmd=CMD_SET_ENA, ptr=36'd0 -> DIV.
  - DIV: cmd=CMD_CLK_DIV, ptr={4'd0, clk_div} -> FETCH if cnt>0, else CNT.
  - FETCH: one cycle; RAM read at address idx -> SLOT.
  - SLOT: cmd=CMD_SLOT_CFG, ptr={ena, cv, idx[7:0], id}. Then idx+1; -> FETCH if idx+1<cnt, else CNT.
  - CNT: cmd=CMD_SLOT_CNT, ptr={27'd0, cnt[8:0]} -> ENA if cnt>0. If cnt==0 -> IDLE with ld_done pulse; the timer is left disabled.
  - ENA: cmd=CMD_SET_ENA, ptr=36'd1 -> IDLE with ld_done pulse.
- idx is a 9-bit counter, cleared in DIS. It indexes without wrap; the clamp guarantees idx < depth.
- Pulses: ld_done or ld_aborted is asserted in the first IDLE cycle. ld_busy falls in that same cycle.
- Abort:
  - ld_abort while busy sets a sticky abort flag.
  - The command in flight completes its handshake. If that command was not DIS, one extra DIS command is issued.
  - Then -> IDLE with a ld_aborted pulse and no ld_done.
  - Abort in IDLE is ignored.
  - ld_abort and ld_start in the same IDLE cycle: start wins and the abort is ignored.
- Reset mid-operation: immediate return to IDLE with stb=0. The timer side resets with the same rst.
- Minimum latency with same-cycle ack:
  - ld_start at T0 -> DIS at T1, DIV at T2.
  - Each slot takes 2 cycles.
  - CNT at T3+2N, ENA at T4+2N, ld_done at T5+2N.

Test Plan:
- Write slots 0,1 = {1,19'd5,8'hA1},{0,19'd9,8'hB2}; start cnt=2, div=32'd100, ack tied to stb -> commands 30/0, 33/100, 31/{1,5,00,A1}, 31/{0,9,01,B2}, 32/2, 30/1; ld_done at T9; busy T1..T8.
- Same load with ack delayed 3 cycles per command -> each cmd/ptr held stable for 4 cycles; order unchanged; no command lost or duplicated.
- cnt=0, div=7 -> 30/0, 33/7, 32/0, then done; no enable command issued.
- cnt=300 -> exactly 256 slot commands with slot fields 0..255; count command carries 9'd256.
- ld_abort asserted during the second slot command with ack held low 2 cycles -> that slot completes, then 30/0 is issued, ld_aborted pulses, no ld_done. Second ld_start during busy -> ignored.
- rst asserted while a DIV command is waiting for ack -> stb=0 the same cycle; after release, a new start runs a full sequence from DIS.
